// File: rtl/cmd_tx.sv
// Remote-side command transmitter: sends a 16-bit command as two 8N1 UART bytes, high byte first.
// TX, tx_busy and cmd_snt are all registered.
module cmd_tx #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        tx_busy,
  output logic        cmd_snt
);

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    HI_START,
    HI_DATA,
    HI_STOP,
    LO_START,
    LO_DATA,
    LO_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [CMD_W-1:0]    hold_q, hold_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                snt_q, snt_d;
  logic                bound;

  assign bound = (baud_q == CNT_W'(BAUD_DIV - 1));

  // Next-state, baud/bit timing and registered line level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    snt_d   = snt_q;
    tx_d    = 1'b1;

    if (state_q != IDLE) begin
      baud_d = bound ? '0 : baud_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          hold_d  = cmd;
          state_d = HI_START;
          busy_d  = 1'b1;
          snt_d   = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      HI_START: begin
        if (bound) begin
          state_d = HI_DATA;
          shift_d = hold_q[15:8];
          bit_d   = '0;
        end
      end
      HI_DATA: begin
        if (bound) begin
          shift_d = {1'b0, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(7)) state_d = HI_STOP;
        end
      end
      HI_STOP: begin
        if (bound) state_d = LO_START;
      end
      LO_START: begin
        if (bound) begin
          state_d = LO_DATA;
          shift_d = hold_q[7:0];
          bit_d   = '0;
        end
      end
      LO_DATA: begin
        if (bound) begin
          shift_d = {1'b0, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(7)) state_d = LO_STOP;
        end
      end
      LO_STOP: begin
        if (bound) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          snt_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the current state, so TX lags the state by one clock
    unique case (state_q)
      HI_START, LO_START: tx_d = 1'b0;
      HI_DATA, LO_DATA:   tx_d = shift_q[0];
      default:            tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      snt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      snt_q   <= snt_d;
    end
  end

  assign TX      = tx_q;
  assign tx_busy = busy_q;
  assign cmd_snt = snt_q;

endmodule
